// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the BRAM port arbiter.
package bram_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Requester ids, used for the priority pointer and the response id.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/bram_sp_nochange.sv
// Single-port block RAM, no-change mode: a write leaves the output register
// untouched, a read loads it. The output register resets asynchronously to 0.
module bram_sp_nochange #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array write; the storage itself has no reset.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= di;
  end

  // Output register: loaded only by reads, held across writes and idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout <= '0;
    else if (en && !we) dout <= mem[addr];
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Post-reset clear sweep plus two-requester round-robin arbiter in front of a
// single-port no-change BRAM. Read data returns one cycle after acceptance.
//
// Handshake: a request transfers on a rising edge where x_valid && x_ready.
// x_ready depends combinationally on x_valid and never rises without it; the
// requester holds valid/we/addr/wdata stable until it sees ready.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output state_t            dbg_state
);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   init_cnt;
  logic                prio;
  logic                rsp_valid;
  logic                rsp_id;
  logic                ram_en, ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_di, ram_dout;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nx;
  end

  // Next state: leave the sweep once the last address is being written.
  always_comb begin
    state_nx = state;
    if (state == ST_INIT && init_cnt == {ADDR_W{1'b1}}) state_nx = ST_RUN;
  end

  // Outputs: sweep writes during ST_INIT, arbitrated request mux in ST_RUN.
  always_comb begin
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    case (state)
      ST_INIT: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = init_cnt;
        ram_di   = INIT_VAL;
      end
      ST_RUN: begin
        a_ready = a_valid && (!b_valid || prio == REQ_A);
        b_ready = b_valid && (!a_valid || prio == REQ_B);
        if (a_ready) begin
          ram_en   = 1'b1;
          ram_we   = a_we;
          ram_addr = a_addr;
          ram_di   = a_wdata;
        end else if (b_ready) begin
          ram_en   = 1'b1;
          ram_we   = b_we;
          ram_addr = b_addr;
          ram_di   = b_wdata;
        end
      end
      default: ;
    endcase
  end

  // Sweep address counter; it only advances while clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    init_cnt <= '0;
    else if (state == ST_INIT)  init_cnt <= init_cnt + 1'b1;
  end

  // Priority pointer moves to the loser of each transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          prio <= REQ_A;
    else if (a_ready) prio <= REQ_B;
    else if (b_ready) prio <= REQ_A;
  end

  // Remember who issued a read so the returning data pulses the right rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= REQ_A;
    end else begin
      rsp_valid <= (a_ready && !a_we) || (b_ready && !b_we);
      rsp_id    <= b_ready ? REQ_B : REQ_A;
    end
  end

  bram_sp_nochange #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .di   (ram_di),
    .dout (ram_dout)
  );

  assign init_done = (state == ST_RUN);
  assign a_rvalid  = rsp_valid && (rsp_id == REQ_A);
  assign b_rvalid  = rsp_valid && (rsp_id == REQ_B);
  assign a_rdata   = ram_dout;
  assign b_rdata   = ram_dout;
  assign dbg_state = state;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomised + directed bench for bram_port_arbiter with a reference model
// (array memory, round-robin rule) and a response scoreboard.
module tb_bram_port_arbiter;
  import bram_arb_pkg::*;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int DEPTH = 64;
  localparam logic [DW-1:0] INIT_V = 16'h0000;
  localparam int EW = 32 + 1 + DW;  // {due cycle, id, data}

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done;
  logic          a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_ready, b_ready, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  state_t        dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int run_start = 0;

  logic [DW-1:0]     mem_m [DEPTH];
  logic              prio_m;
  logic [EW-1:0]     exp_q[$];
  logic [AW+DW:0]    a_fifo[$];
  logic [AW+DW:0]    b_fifo[$];
  logic [DW-1:0]     last_rd;

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_VAL(INIT_V)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [AW+DW:0] req(input bit we, input int addr, input int data);
    return {we, AW'(addr), DW'(data)};
  endfunction

  // Model side of a transfer: writes update the array, reads queue a response.
  task automatic apply(input logic id, input logic [AW+DW:0] r);
    if (r[AW+DW]) mem_m[r[AW+DW-1:DW]] = r[DW-1:0];
    else exp_q.push_back({32'(cyc + 1), id, mem_m[r[AW+DW-1:DW]]});
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    bit run, ga, gb;
    @(negedge clk);
    a_valid = a_fifo.size() > 0;
    b_valid = b_fifo.size() > 0;
    {a_we, a_addr, a_wdata} = a_valid ? a_fifo[0] : '0;
    {b_we, b_addr, b_wdata} = b_valid ? b_fifo[0] : '0;
    #1;
    run = (cyc - run_start) >= DEPTH;
    ga = run && a_valid && (!b_valid || prio_m == REQ_A);
    gb = run && b_valid && (!a_valid || prio_m == REQ_B);
    chk("init_done", 32'(init_done), 32'(run));
    chk("a_ready", 32'(a_ready), 32'(ga));
    chk("b_ready", 32'(b_ready), 32'(gb));
    if (ga) begin
      apply(REQ_A, a_fifo.pop_front());
      prio_m = REQ_B;
    end else if (gb) begin
      apply(REQ_B, b_fifo.pop_front());
      prio_m = REQ_A;
    end
  endtask

  task automatic run_until_empty();
    int n = 0;
    while (a_fifo.size() > 0 || b_fifo.size() > 0) begin
      cycle();
      n++;
      if (n > 3000) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d cycles expected <= 3000", n);
        a_fifo.delete();
        b_fifo.delete();
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    prio_m = REQ_A;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT_V;
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst_rdata", 32'(a_rdata), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_start = cyc;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    #2;
    if (rst) begin
      last_rd = '0;
      chk("mon_rst_a_rvalid", 32'(a_rvalid), 32'd0);
      chk("mon_rst_b_rvalid", 32'(b_rvalid), 32'd0);
      chk("mon_rst_rdata", 32'(a_rdata), 32'd0);
    end else begin
      while (exp_q.size() > 0 && int'(exp_q[0][EW-1:DW+1]) < cyc) begin
        e = exp_q.pop_front();
        chk("missed_rvalid", 32'd0, 32'd1);
      end
      if (exp_q.size() > 0 && int'(exp_q[0][EW-1:DW+1]) == cyc) begin
        e = exp_q.pop_front();
        chk("a_rvalid", 32'(a_rvalid), 32'(e[DW] == REQ_A));
        chk("b_rvalid", 32'(b_rvalid), 32'(e[DW] == REQ_B));
        if (e[DW] == REQ_A) chk("a_rdata", 32'(a_rdata), 32'(e[DW-1:0]));
        else                chk("b_rdata", 32'(b_rdata), 32'(e[DW-1:0]));
        last_rd = e[DW-1:0];
      end else begin
        chk("idle_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("idle_b_rvalid", 32'(b_rvalid), 32'd0);
        chk("hold_a_rdata", 32'(a_rdata), 32'(last_rd));
        chk("hold_b_rdata", 32'(b_rdata), 32'(last_rd));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    last_rd = '0;
    // Both requesters waiting from cycle 0; A then sweeps every address.
    b_fifo.push_back(req(0, 0, 0));
    for (int i = 0; i < DEPTH; i++) a_fifo.push_back(req(0, i, 0));
    do_reset();
    run_until_empty();

    // Write then read back on A.
    a_fifo.push_back(req(1, 5, 16'h1234));
    a_fifo.push_back(req(0, 5, 0));
    run_until_empty();

    // Continuous reads from both: strict alternation.
    for (int i = 0; i < 8; i++) begin
      a_fifo.push_back(req(0, i, 0));
      b_fifo.push_back(req(0, 8 + i, 0));
    end
    run_until_empty();

    // No-change: B reads 0xBEEF, A overwrites, rdata holds, later read sees new.
    a_fifo.push_back(req(1, 9, 16'hBEEF));
    run_until_empty();
    b_fifo.push_back(req(0, 9, 0));
    run_until_empty();
    a_fifo.push_back(req(1, 9, 16'h5555));
    run_until_empty();
    repeat (3) cycle();
    b_fifo.push_back(req(0, 9, 0));
    run_until_empty();

    // B writes top address, A reads it the very next cycle.
    b_fifo.push_back(req(1, 63, 16'hAAAA));
    run_until_empty();
    a_fifo.push_back(req(0, 63, 0));
    run_until_empty();

    // Random traffic with address collisions.
    for (int n = 0; n < 400; n++) begin
      if (a_fifo.size() == 0 && $urandom_range(0, 2) != 0)
        a_fifo.push_back(req($urandom_range(0, 1), ($urandom_range(0, 4) == 0) ? 63 : $urandom_range(0, 7),
                             $urandom_range(0, 16'hFFFF)));
      if (b_fifo.size() == 0 && $urandom_range(0, 2) != 0)
        b_fifo.push_back(req($urandom_range(0, 1), ($urandom_range(0, 4) == 0) ? 63 : $urandom_range(0, 7),
                             $urandom_range(0, 16'hFFFF)));
      cycle();
    end
    run_until_empty();

    // Reset right after a read accept: the response is dropped, contents cleared.
    a_fifo.push_back(req(1, 20, 16'h7777));
    run_until_empty();
    a_fifo.push_back(req(0, 20, 0));
    run_until_empty();
    @(posedge clk);
    #2;
    do_reset();
    a_fifo.push_back(req(0, 20, 0));
    run_until_empty();
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
